// File: rtl/sa_result_drain_pkg.sv
// Shared definitions for the systolic-array result drain stage.
package sa_result_drain_pkg;

  // Default array geometry and operand width
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_HPE   = 8;
  localparam int unsigned DEF_VPE   = 8;

  // Two-state drain FSM
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Index width that stays at least one bit for degenerate sizes
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of element e in a flat bus where element 0 occupies the MSBs
  function automatic int unsigned elem_lsb(input int unsigned e,
                                           input int unsigned nelem,
                                           input int unsigned res_w);
    return (nelem - e - 1) * res_w;
  endfunction

endpackage

// File: rtl/sa_result_drain.sv
// Captures the array result bus on CAP and streams it out one element per
// valid/ready beat, tagged with row/col/last, so the array can move on.
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned HPE   = DEF_HPE,
  parameter int unsigned VPE   = DEF_VPE
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [2*WIDTH*HPE*VPE-1:0]    Y,
  input  logic                          CAP,
  output logic [2*WIDTH-1:0]            OUT_DATA,
  output logic [idx_w(HPE)-1:0]         OUT_ROW,
  output logic [idx_w(VPE)-1:0]         OUT_COL,
  output logic                          OUT_LAST,
  output logic                          OUT_VLD,
  input  logic                          OUT_RDY,
  output logic                          BUSY,
  output logic                          DROP,
  output logic                          DROP_STKY
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned NELEM = HPE * VPE;
  localparam int unsigned IW    = idx_w(NELEM);
  localparam int unsigned RW    = idx_w(HPE);
  localparam int unsigned CW    = idx_w(VPE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NELEM - 1);

  drain_state_e             state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [RES_W*NELEM-1:0]   snap_q, snap_d;
  logic                     drop_q, drop_d;
  logic                     stky_q, stky_d;

  logic                     hs;
  logic                     at_last;
  logic                     take_cap;
  logic                     drop_evt;
  logic [31:0]              idx_ext;
  logic [RES_W-1:0]         elem [NELEM];
  logic [RES_W-1:0]         sel_data;

  // Handshake, last-element and capture-acceptance decode
  assign hs       = (state_q == ST_DRAIN) && OUT_RDY;
  assign at_last  = (idx_q == LAST_IDX);
  assign take_cap = CAP && ((state_q == ST_IDLE) || (hs && at_last));
  assign drop_evt = CAP && !take_cap;
  assign idx_ext  = 32'(idx_q);

  // Split the snapshot bank into elements; element 0 sits at the MSBs
  for (genvar e = 0; e < NELEM; e++) begin : g_elem
    assign elem[e] = snap_q[elem_lsb(e, NELEM, RES_W) +: RES_W];
  end

  // NELEM:1 element select driven by the registered index
  assign sel_data = elem[idx_q];

  // State and datapath registers; reset discards any in-flight tile
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      drop_q  <= 1'b0;
      stky_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      drop_q  <= drop_d;
      stky_q  <= stky_d;
    end
  end

  // Next-state: leave DRAIN only when the last beat completes without a recapture
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CAP) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (hs && at_last && !CAP) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: snapshot/index update and drop reporting
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    drop_d = 1'b0;
    stky_d = stky_q;
    if (take_cap) begin
      snap_d = Y;
      idx_d  = '0;
    end else if (hs) begin
      idx_d = at_last ? '0 : idx_q + IW'(1);
    end
    if (drop_evt) begin
      drop_d = 1'b1;
      stky_d = 1'b1;
    end
  end

  // Outputs: pure function of registered state, so they hold during stalls
  always_comb begin
    OUT_VLD   = 1'b0;
    BUSY      = 1'b0;
    OUT_DATA  = '0;
    OUT_ROW   = '0;
    OUT_COL   = '0;
    OUT_LAST  = 1'b0;
    DROP      = drop_q;
    DROP_STKY = stky_q;
    if (state_q == ST_DRAIN) begin
      OUT_VLD  = 1'b1;
      BUSY     = 1'b1;
      OUT_DATA = sel_data;
      OUT_ROW  = RW'(idx_ext / VPE);
      OUT_COL  = CW'(idx_ext % VPE);
      OUT_LAST = at_last;
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: driver pushes expected beats,
// monitor pops and compares on every presented output.
`timescale 1ns/1ps
module tb_sa_result_drain;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned HPE   = 8;
  localparam int unsigned VPE   = 8;
  localparam int unsigned NELEM = HPE * VPE;
  localparam int unsigned RESW  = 2 * WIDTH;

  typedef struct packed {
    logic [RESW-1:0] data;
    logic [2:0]      row;
    logic [2:0]      col;
    logic            last;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [RESW*NELEM-1:0]   y;
  logic                    cap;
  logic                    out_rdy;
  logic [RESW-1:0]         out_data;
  logic [2:0]              out_row;
  logic [2:0]              out_col;
  logic                    out_last;
  logic                    out_vld;
  logic                    busy;
  logic                    drop;
  logic                    drop_stky;

  beat_t                   exp_q[$];
  logic [RESW-1:0]         yv[NELEM];
  logic                    drop_flag = 1'b0;
  int                      checks = 0;
  int                      failures = 0;

  always #0.75 clk = ~clk;

  sa_result_drain #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) dut (
    .CLK(clk), .RST(rst), .Y(y), .CAP(cap),
    .OUT_DATA(out_data), .OUT_ROW(out_row), .OUT_COL(out_col),
    .OUT_LAST(out_last), .OUT_VLD(out_vld), .OUT_RDY(out_rdy),
    .BUSY(busy), .DROP(drop), .DROP_STKY(drop_stky)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Pack the model's element array onto the flat bus
  task automatic drive_y();
    for (int e = 0; e < int'(NELEM); e++)
      y[(NELEM - e) * RESW - 1 -: RESW] = yv[e];
  endtask

  // One clock of stimulus; decides from the model whether a capture is taken
  task automatic cycle(input logic c, input logic r);
    beat_t snap[$];
    bit    accept;
    out_rdy = r;
    cap     = c;
    accept  = 1'b0;
    if (c) begin
      accept = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
      if (accept) begin
        for (int e = 0; e < int'(NELEM); e++)
          snap.push_back('{data: yv[e], row: 3'(e / int'(VPE)),
                           col: 3'(e % int'(VPE)), last: (e == int'(NELEM) - 1)});
      end else begin
        drop_flag = 1'b1;
      end
    end
    @(posedge clk);
    #0.2;
    cap = 1'b0;
    foreach (snap[i]) exp_q.push_back(snap[i]);
  endtask

  function automatic logic pick_rdy(input int mode, input int k);
    logic pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[k % 6];
    return logic'($urandom_range(0, 3) != 0);
  endfunction

  // Run until the model has no outstanding beats, bounded by a cycle budget
  task automatic drain(input int mode);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cycle(1'b0, pick_rdy(mode, n));
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout remaining=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_ramp(input logic [RESW-1:0] base);
    for (int e = 0; e < int'(NELEM); e++) yv[e] = base + RESW'(e);
    drive_y();
  endtask

  // Monitor: scoreboard compare, stall stability, valid/busy/drop tracking
  initial begin : monitor
    logic  drop_prev;
    logic  stky_m;
    logic  stall_prev;
    beat_t held;
    beat_t cur;
    drop_prev  = 1'b0;
    stky_m     = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        drop_prev  = 1'b0;
        stky_m     = 1'b0;
        stall_prev = 1'b0;
        drop_flag  = 1'b0;
      end else begin
        stky_m = stky_m | drop_prev;
        chk("drop", 64'(drop), 64'(drop_prev));
        chk("drop_stky", 64'(drop_stky), 64'(stky_m));
        chk("out_vld", 64'(out_vld), 64'(exp_q.size() != 0));
        chk("busy", 64'(busy), 64'(exp_q.size() != 0));
        if (out_vld && exp_q.size() != 0) begin
          cur = '{data: out_data, row: out_row, col: out_col, last: out_last};
          if (stall_prev) chk("stall_hold", 64'(cur), 64'(held));
          chk("beat", 64'(cur), 64'(exp_q[0]));
          if (out_rdy) begin
            void'(exp_q.pop_front());
            stall_prev = 1'b0;
          end else begin
            stall_prev = 1'b1;
            held       = cur;
          end
        end else begin
          stall_prev = 1'b0;
        end
        drop_prev = drop_flag;
        drop_flag = 1'b0;
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic
  initial begin : driver
    rst     = 1'b1;
    cap     = 1'b0;
    out_rdy = 1'b0;
    y       = '0;
    for (int e = 0; e < int'(NELEM); e++) yv[e] = '0;
    repeat (3) @(posedge clk);
    #0.2;
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_rowcol", 64'({out_row, out_col}), 64'd0);
    chk("rst_drop", 64'({drop, drop_stky}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #0.2;

    // Single tile, sink always ready
    set_ramp(32'h0000_0100);
    cycle(1'b1, 1'b1);
    drain(0);
    repeat (2) cycle(1'b0, 1'b1);

    // Backpressure pattern 1,0,0,1,1,0
    cycle(1'b1, 1'b1);
    drain(1);
    repeat (2) cycle(1'b0, 1'b0);

    // Snapshot isolation: Y overwritten right after capture
    cycle(1'b1, 1'b1);
    for (int e = 0; e < int'(NELEM); e++) yv[e] = 32'hDEAD_BEEF;
    drive_y();
    drain(2);

    // Capture during drain at beat 10 is dropped
    set_ramp(32'h0000_0100);
    cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b0, 1'b1);
    set_ramp(32'h0000_0300);
    cycle(1'b1, 1'b1);
    set_ramp(32'h0000_0100);
    drain(0);
    repeat (2) cycle(1'b0, 1'b1);

    // Back-to-back tiles: recapture on the last-beat handshake
    cycle(1'b1, 1'b1);
    for (int n = 0; n < 200 && exp_q.size() > 1; n++) cycle(1'b0, 1'b1);
    set_ramp(32'h0000_0200);
    cycle(1'b1, 1'b1);
    drain(0);

    // Reset mid-drain at beat 20
    set_ramp(32'h0000_0100);
    cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b1);
    chk("stky_before_rst", 64'(drop_stky), 64'd1);
    #0.1;
    rst = 1'b1;
    #0.1;
    chk("midrst_vld", 64'(out_vld), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stky", 64'(drop_stky), 64'd0);
    exp_q.delete();
    drop_flag = 1'b0;
    repeat (2) @(posedge clk);
    #0.2;
    rst = 1'b0;
    @(posedge clk);
    #0.2;
    set_ramp(32'h0000_0400);
    cycle(1'b1, 1'b1);
    drain(1);

    // Randomized tiles with random backpressure and stray captures
    for (int t = 0; t < 6; t++) begin
      for (int e = 0; e < int'(NELEM); e++) yv[e] = $urandom;
      drive_y();
      cycle(1'b1, pick_rdy(2, 0));
      for (int n = 0; n < 150; n++) begin
        logic c;
        c = ($urandom_range(0, 19) == 0);
        if (c) begin
          for (int e = 0; e < int'(NELEM); e++) yv[e] = $urandom;
          drive_y();
        end
        cycle(c, pick_rdy(2, n));
      end
      drain(2);
    end

    repeat (3) cycle(1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
